snake_frame_renderer: RTL and testbench

Pixel stage directly downstream of the VGA timing generator. It consumes `hcount`, `vcount` and `displayArea` on the 25 MHz pixel clock and produces 4-bit RGB for the snake game. It owns the snake body buffer (up to `MAX_LEN` cell coordinates on a 40×30 grid of 16×16-pixel cells), the game food, and the self-collision and food detection. Moves requested by game control are applied only at the start of vertical blanking, so a frame never tears.

---
 rtl/snake_frame_renderer.sv | 223 ++++++++++++++++++++++
 tb/tb_snake_frame_renderer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_renderer.sv
// Snake game pixel stage: body buffer, frame-synchronous moves, food/self-collision detection, 2-cycle RGB pipeline.
// Build option: define SNAKE_GRID_EN to draw grid lines on background cells.
module snake_frame_renderer #(
   parameter int MAX_LEN = 16,
   parameter int GRID_W  = 40,
   parameter int GRID_H  = 30
) (
   input  logic       VGA_clk,
   input  logic       rst,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       displayArea,
   input  logic       move_pulse,
   input  logic [1:0] dir,
   input  logic       grow,
   input  logic [5:0] food_x,
   input  logic [4:0] food_y,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic [5:0] length,
   output logic       ate,
   output logic       self_hit
);

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_e;

   localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
   localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

   // Body buffer; index 0 is the head.
   logic [5:0] seg_x_q [MAX_LEN];
   logic [5:0] seg_x_d [MAX_LEN];
   logic [4:0] seg_y_q [MAX_LEN];
   logic [4:0] seg_y_d [MAX_LEN];

   logic [5:0] len_q, len_d;
   dir_e       dir_q, dir_d;
   dir_e       pdir_q, pdir_d;
   logic       pend_q, pend_d;
   logic       pgrow_q, pgrow_d;
   logic       ate_q, ate_d;
   logic       hit_q, hit_d;

   // Move request as seen this cycle: a strobe coincident with the update point wins over the latches.
   dir_e       req_dir;
   logic       req_grow;
   logic       req_pend;
   logic       upd_pt;
   dir_e       step_dir;
   logic [5:0] new_x;
   logic [4:0] new_y;
   logic       collide;

   // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
   always_comb begin
      req_dir  = move_pulse ? dir_e'(dir) : pdir_q;
      req_grow = move_pulse ? grow : pgrow_q;
      req_pend = pend_q | move_pulse;
      upd_pt   = (vcount == 10'd480) && (hcount == 10'd0);

      step_dir = ((req_dir ^ dir_q) == 2'b10) ? dir_q : req_dir;

      new_x = seg_x_q[0];
      new_y = seg_y_q[0];
      case (step_dir)
         DIR_RIGHT: new_x = (seg_x_q[0] == X_MAX) ? 6'd0 : seg_x_q[0] + 6'd1;
         DIR_LEFT:  new_x = (seg_x_q[0] == 6'd0) ? X_MAX : seg_x_q[0] - 6'd1;
         DIR_DOWN:  new_y = (seg_y_q[0] == Y_MAX) ? 5'd0 : seg_y_q[0] + 5'd1;
         DIR_UP:    new_y = (seg_y_q[0] == 5'd0) ? Y_MAX : seg_y_q[0] - 5'd1;
         default:   ;
      endcase

      // Only segments that survive the shift can be hit: old seg[0..length-2].
      collide = 1'b0;
      for (int i = 0; i < MAX_LEN - 1; i++) begin
         if ((6'(i) < len_q - 6'd1) && (seg_x_q[i] == new_x) && (seg_y_q[i] == new_y))
            collide = 1'b1;
      end
   end

   // NOTE: next-state logic uses blocking '=' in always_comb; registers are written with '<=' only.
   always_comb begin
      pend_d  = pend_q;
      pdir_d  = pdir_q;
      pgrow_d = pgrow_q;
      dir_d   = dir_q;
      len_d   = len_q;
      ate_d   = 1'b0;
      hit_d   = hit_q;
      seg_x_d = seg_x_q;
      seg_y_d = seg_y_q;

      if (move_pulse) begin
         pend_d  = 1'b1;
         pdir_d  = dir_e'(dir);
         pgrow_d = grow;
      end

      if (upd_pt) begin
         pend_d = 1'b0;
         if (req_pend && !hit_q) begin
            dir_d      = step_dir;
            seg_x_d[0] = new_x;
            seg_y_d[0] = new_y;
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x_d[i] = seg_x_q[i-1];
               seg_y_d[i] = seg_y_q[i-1];
            end
            if (req_grow && (len_q < 6'(MAX_LEN)))
               len_d = len_q + 6'd1;
            hit_d = collide;
            ate_d = (new_x == food_x) && (new_y == food_y);
         end
      end
   end

   // NOTE: the body buffer is small enough to reset like any register, keeping the compare logic X-free.
   always_ff @(posedge VGA_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= (i < 3) ? 6'(20 - i) : 6'd0;
            seg_y_q[i] <= (i < 3) ? 5'd15 : 5'd0;
         end
         len_q   <= 6'd3;
         dir_q   <= DIR_RIGHT;
         pdir_q  <= DIR_RIGHT;
         pend_q  <= 1'b0;
         pgrow_q <= 1'b0;
         ate_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         seg_x_q <= seg_x_d;
         seg_y_q <= seg_y_d;
         len_q   <= len_d;
         dir_q   <= dir_d;
         pdir_q  <= pdir_d;
         pend_q  <= pend_d;
         pgrow_q <= pgrow_d;
         ate_q   <= ate_d;
         hit_q   <= hit_d;
      end
   end

   // Stage 1: cell-match flags for the pixel at hcount/vcount.
   logic [5:0] cell_x;
   logic [4:0] cell_y;
   logic       head_m, body_m, food_m;
   logic       head_q, body_q, food_q;
`ifdef SNAKE_GRID_EN
   logic       grid_m, grid_q;
`endif

   always_comb begin
      cell_x = hcount[9:4];
      cell_y = vcount[8:4];
      head_m = (cell_x == seg_x_q[0]) && (cell_y == seg_y_q[0]);
      food_m = (cell_x == food_x) && (cell_y == food_y);
      body_m = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((6'(i) < len_q) && (cell_x == seg_x_q[i]) && (cell_y == seg_y_q[i]))
            body_m = 1'b1;
      end
`ifdef SNAKE_GRID_EN
      grid_m = (hcount[3:0] == 4'd0) || (vcount[3:0] == 4'd0);
`endif
   end

   always_ff @(posedge VGA_clk or posedge rst) begin
      if (rst) begin
         head_q <= 1'b0;
         body_q <= 1'b0;
         food_q <= 1'b0;
`ifdef SNAKE_GRID_EN
         grid_q <= 1'b0;
`endif
      end else begin
         head_q <= head_m;
         body_q <= body_m;
         food_q <= food_m;
`ifdef SNAKE_GRID_EN
         grid_q <= grid_m;
`endif
      end
   end

   // Stage 2: displayArea lags the counters by one cycle, so it lines up with the stage-1 flags here.
   logic [11:0] rgb_d, rgb_q;

   always_comb begin
      rgb_d = 12'h000;
      if (displayArea) begin
         if (head_q)      rgb_d = 12'h0F0;
         else if (body_q) rgb_d = 12'h0A0;
         else if (food_q) rgb_d = 12'hF00;
         else begin
`ifdef SNAKE_GRID_EN
            rgb_d = grid_q ? 12'h222 : 12'h002;
`else
            rgb_d = 12'h002;
`endif
         end
      end
   end

   always_ff @(posedge VGA_clk or posedge rst) begin
      if (rst) rgb_q <= 12'h000;
      else     rgb_q <= rgb_d;
   end

   assign red      = rgb_q[11:8];
   assign green    = rgb_q[7:4];
   assign blue     = rgb_q[3:0];
   assign length   = len_q;
   assign ate      = ate_q;
   assign self_hit = hit_q;

endmodule

// File: tb/tb_snake_frame_renderer.sv
// Directed bench for snake_frame_renderer: counters are driven directly, one probe pixel or update point at a time.
module tb_snake_frame_renderer;

   logic       VGA_clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = 10'd500;
   logic       displayArea = 1'b0;
   logic       move_pulse = 1'b0;
   logic [1:0] dir = 2'd0;
   logic       grow = 1'b0;
   logic [5:0] food_x = 6'd5;
   logic [4:0] food_y = 5'd5;
   logic [3:0] red, green, blue;
   logic [5:0] length;
   logic       ate, self_hit;

   int tests = 0;
   int fails = 0;

   snake_frame_renderer dut (
      .VGA_clk     (VGA_clk),
      .rst         (rst),
      .hcount      (hcount),
      .vcount      (vcount),
      .displayArea (displayArea),
      .move_pulse  (move_pulse),
      .dir         (dir),
      .grow        (grow),
      .food_x      (food_x),
      .food_y      (food_y),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .length      (length),
      .ate         (ate),
      .self_hit    (self_hit)
   );

   always #20 VGA_clk = ~VGA_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Idle position is in vertical blanking, away from the update point.
   task automatic idle();
      hcount      = 10'd0;
      vcount      = 10'd500;
      displayArea = 1'b0;
      move_pulse  = 1'b0;
   endtask

   task automatic check_px(input string tag, input int h, input int v, input logic de,
                           input logic [11:0] exp);
      @(negedge VGA_clk);
      hcount = 10'(h);
      vcount = 10'(v);
      displayArea = 1'b0;
      @(negedge VGA_clk);
      hcount = 10'd0;
      vcount = 10'd500;
      displayArea = de;
      @(negedge VGA_clk);
      displayArea = 1'b0;
      check(tag, {4'h0, red, green, blue}, {4'h0, exp});
   endtask

   task automatic check_cell(input string tag, input int cx, input int cy, input logic [11:0] exp);
      check_px(tag, cx * 16 + 8, cy * 16 + 8, 1'b1, exp);
   endtask

   task automatic pulse(input logic [1:0] d, input logic g);
      @(negedge VGA_clk);
      move_pulse = 1'b1;
      dir = d;
      grow = g;
      @(negedge VGA_clk);
      move_pulse = 1'b0;
      grow = 1'b0;
   endtask

   // Returns in the cycle after the update point, where ate is visible.
   task automatic update();
      @(negedge VGA_clk);
      hcount = 10'd0;
      vcount = 10'd480;
      @(negedge VGA_clk);
      vcount = 10'd500;
   endtask

   task automatic update_with_pulse(input logic [1:0] d);
      @(negedge VGA_clk);
      hcount = 10'd0;
      vcount = 10'd480;
      move_pulse = 1'b1;
      dir = d;
      @(negedge VGA_clk);
      move_pulse = 1'b0;
      vcount = 10'd500;
   endtask

   task automatic move(input logic [1:0] d, input logic g);
      pulse(d, g);
      update();
   endtask

   initial begin
      idle();
      repeat (3) @(negedge VGA_clk);
      check("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
      check("rst_len", 16'(length), 16'd3);
      check("rst_ate", 16'(ate), 16'd0);
      check("rst_hit", 16'(self_hit), 16'd0);
      rst = 1'b0;

      // Reset image.
      check_px("head_328_248", 328, 248, 1'b1, 12'h0F0);
      check_px("body_312_248", 312, 248, 1'b1, 12'h0A0);
      check_px("body_296_248", 296, 248, 1'b1, 12'h0A0);
      check_px("bg_0_0", 0, 0, 1'b1, 12'h002);
      check_px("food_88_88", 88, 88, 1'b1, 12'hF00);
      check_px("blank_de0", 328, 248, 1'b0, 12'h000);

      // Five steps right: head 20 -> 25, body 24, 23.
      for (int i = 0; i < 5; i++) move(2'd0, 1'b0);
      check("ate_no_food", 16'(ate), 16'd0);
      check_cell("r5_head", 25, 15, 12'h0F0);
      check_cell("r5_body", 24, 15, 12'h0A0);
      check_cell("r5_clear", 22, 15, 12'h002);
      check("r5_len", 16'(length), 16'd3);

      // Reversal request is ignored, the snake keeps going right.
      move(2'd2, 1'b0);
      check_cell("rev_head", 26, 15, 12'h0F0);
      check_cell("rev_body", 25, 15, 12'h0A0);

      // Fourteen more steps: 26 -> 39 -> wrap to 0.
      for (int i = 0; i < 14; i++) move(2'd0, 1'b0);
      check_cell("wrap_head", 0, 15, 12'h0F0);
      check_cell("wrap_body39", 39, 15, 12'h0A0);
      check_cell("wrap_body38", 38, 15, 12'h0A0);
      check_cell("wrap_clear37", 37, 15, 12'h002);

      // Eat food at (1,15) while growing.
      food_x = 6'd1;
      food_y = 5'd15;
      move(2'd0, 1'b1);
      check("ate_pulse", 16'(ate), 16'd1);
      @(negedge VGA_clk);
      check("ate_clear", 16'(ate), 16'd0);
      check("eat_len", 16'(length), 16'd4);
      check_cell("eat_head_over_food", 1, 15, 12'h0F0);
      food_x = 6'd5;
      food_y = 5'd5;

      // Grow to the limit, then one more grow leaves length at 16 and drops the tail.
      for (int i = 0; i < 12; i++) move(2'd0, 1'b1);
      check("max_len", 16'(length), 16'd16);
      move(2'd0, 1'b1);
      check("max_len_hold", 16'(length), 16'd16);
      check_cell("max_head", 14, 15, 12'h0F0);
      check_cell("max_tail", 39, 15, 12'h0A0);
      check_cell("max_dropped", 38, 15, 12'h002);

      // Reset in the middle of a visible line.
      @(negedge VGA_clk);
      hcount = 10'd0;
      vcount = 10'd200;
      displayArea = 1'b1;
      repeat (2) @(negedge VGA_clk);
      check("pre_rst_bg", {4'h0, red, green, blue}, 16'h0002);
      #5 rst = 1'b1;
      #1;
      check("mid_rst_rgb", {4'h0, red, green, blue}, 16'h0000);
      check("mid_rst_len", 16'(length), 16'd3);
      @(negedge VGA_clk);
      rst = 1'b0;
      idle();
      check_cell("post_rst_head", 20, 15, 12'h0F0);
      check_cell("post_rst_body", 19, 15, 12'h0A0);
      check_cell("post_rst_old_head", 14, 15, 12'h002);

      // Grow to 5, then down, left, up runs into the body at (21,15).
      move(2'd0, 1'b1);
      move(2'd0, 1'b1);
      check("coll_len5", 16'(length), 16'd5);
      move(2'd1, 1'b0);
      move(2'd2, 1'b0);
      check("coll_not_yet", 16'(self_hit), 16'd0);
      move(2'd3, 1'b0);
      check("coll_hit", 16'(self_hit), 16'd1);
      check_cell("coll_head", 21, 15, 12'h0F0);
      move(2'd0, 1'b0);
      check("coll_sticky", 16'(self_hit), 16'd1);
      check_cell("coll_frozen_head", 21, 15, 12'h0F0);
      check_cell("coll_frozen_body", 22, 15, 12'h0A0);
      check("coll_frozen_len", 16'(length), 16'd5);

      // Three pulses in one frame (last one wins) produce exactly one step.
      @(negedge VGA_clk);
      rst = 1'b1;
      @(negedge VGA_clk);
      rst = 1'b0;
      check("rst_clears_hit", 16'(self_hit), 16'd0);
      pulse(2'd1, 1'b0);
      pulse(2'd1, 1'b0);
      pulse(2'd0, 1'b0);
      update();
      check_cell("multi_head", 21, 15, 12'h0F0);
      check_cell("multi_no_down", 20, 16, 12'h002);
      check_cell("multi_no_2nd", 22, 15, 12'h002);
      update();
      check_cell("idle_update_head", 21, 15, 12'h0F0);

      // A pulse coincident with the update point is used immediately.
      update_with_pulse(2'd1);
      check_cell("same_cycle_head", 21, 16, 12'h0F0);
      check_cell("same_cycle_body", 21, 15, 12'h0A0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
